// File: rtl/load_store_unit.sv
// RV32I memory-stage load/store unit: effective address, legality checks,
// one-cycle data_memory strobe and a registered valid/ready response.
module load_store_unit #(
    parameter int unsigned MEM_SIZE_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_store_data,
    input  logic [4:0]  req_rd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_load_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_is_store,
    output logic        rsp_misaligned,
    output logic        rsp_fault,
    output logic [31:0] rsp_fault_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_next;
    logic        accept;

    logic [31:0] addr_q, wdata_q, load_data_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic        st_q, mis_q, fault_q;

    logic [31:0] eff_addr;
    logic [32:0] end_addr;
    logic [2:0]  size;
    logic        f3_legal, misaligned, out_of_range, err_mis, err_fault;

    assign eff_addr = req_base + req_offset;

    always_comb begin
        f3_legal = req_is_store ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                                : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        case (req_funct3[1:0])
            2'b00:   size = 3'd1;
            2'b01:   size = 3'd2;
            default: size = 3'd4;
        endcase
        misaligned = (req_funct3[1:0] == 2'b01 && eff_addr[0]) ||
                     (req_funct3[1:0] == 2'b10 && eff_addr[1:0] != 2'b00);
        // 33-bit sum so an address that wraps past 2^32 still reads as out of range
        end_addr     = {1'b0, eff_addr} + {30'd0, size};
        out_of_range = end_addr > 33'(MEM_SIZE_BYTES);
        err_mis      = f3_legal && misaligned;
        err_fault    = !f3_legal || (!misaligned && out_of_range);
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = (err_mis || err_fault) ? RESP : ACCESS;
                end
            end
            ACCESS:  state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
            f3_q        <= '0;
            rd_q        <= '0;
            st_q        <= 1'b0;
            mis_q       <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            if (accept) begin
                addr_q      <= eff_addr;
                wdata_q     <= req_store_data;
                f3_q        <= req_funct3;
                rd_q        <= req_rd;
                st_q        <= req_is_store;
                mis_q       <= err_mis;
                fault_q     <= err_fault;
                load_data_q <= '0;
            end
            if (state == ACCESS && !st_q)
                load_data_q <= mem_read_data;
            if (state == RESP && rsp_ready) begin
                mis_q       <= 1'b0;
                fault_q     <= 1'b0;
                load_data_q <= '0;
            end
        end
    end

    assign req_ready      = (state == IDLE);
    assign rsp_valid      = (state == RESP);
    assign rsp_load_data  = load_data_q;
    assign rsp_rd         = rd_q;
    assign rsp_is_store   = st_q;
    assign rsp_misaligned = mis_q;
    assign rsp_fault      = fault_q;
    assign rsp_fault_addr = addr_q;

    // Strobe is masked by reset so a reset during ACCESS never commits a store
    assign mem_read       = (state == ACCESS) && !st_q && !rst;
    assign mem_write      = (state == ACCESS) &&  st_q && !rst;
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_funct3     = f3_q;

endmodule
